// File: rtl/regset_dump_pkg.sv
// Shared widths and state encoding for the regset readout initiator.
// Widths match the regset read port so the dump can be wired straight onto it.
package regset_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regset_dump_if.sv
// Bundle of the regset read port, the dump request and the addr/data output stream.
// master = the dump engine, slave = the regset/consumer/debug side.
interface regset_dump_if
  import regset_dump_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] A_Q;
  logic [DATA_W-1:0] Q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, last_addr, Q, out_ready,
    output A_Q, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, Q, out_ready,
    input  A_Q, out_valid, out_data, out_addr, out_last, busy, done
  );

endinterface

// File: rtl/regset_dump.sv
// Walks a (possibly wrapping) register range through one regset read port and
// streams each value out as an addr/data word under valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; range latched on start
// READ    | A_Q=cur, capture Q into the output registers at the edge
// PRESENT | word held on the stream until the consumer takes it
// FINISH  | one-cycle done pulse
module regset_dump
  import regset_dump_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter bit SKIP_ZERO = 1'b0
) (
  input logic         CLK,
  input logic         RES,
  regset_dump_if.master bus
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cur, end_addr;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              valid_q;
  logic [ADDR_W-1:0] first_eff;
  logic              skip_empty;
  logic              hit_end;
  logic              xfer;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    n = a + ADDR_W'(1);
    if (SKIP_ZERO && (n == '0))
      n = ADDR_W'(1);
    return n;
  endfunction

  assign first_eff  = (SKIP_ZERO && (bus.first_addr == '0)) ? ADDR_W'(1) : bus.first_addr;
  assign skip_empty = SKIP_ZERO && (bus.first_addr == '0) && (bus.last_addr == '0);
  // With zero skipped, an end address of 0 is unreachable; the top address
  // then closes the range instead so the walk cannot loop forever.
  assign hit_end    = (cur == end_addr) || (SKIP_ZERO && (end_addr == '0) && (cur == '1));
  assign xfer       = valid_q && bus.out_ready;

  always_ff @(posedge CLK) begin
    if (RES)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.A_Q   = '0;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start)
          state_nxt = skip_empty ? ST_FINISH : ST_READ;
      end
      ST_READ: begin
        bus.A_Q   = cur;
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        bus.A_Q = cur;
        if (xfer)
          state_nxt = last_q ? ST_FINISH : ST_READ;
      end
      ST_FINISH: begin
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cur      <= '0;
      end_addr <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cur      <= first_eff;
            end_addr <= bus.last_addr;
          end
        end
        ST_READ: begin
          data_q  <= bus.Q;
          addr_q  <= cur;
          last_q  <= hit_end;
          valid_q <= 1'b1;
        end
        ST_PRESENT: begin
          if (xfer) begin
            valid_q <= 1'b0;
            if (!last_q)
              cur <= next_addr(cur);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_regset_dump.sv
// Bench for regset_dump: one plain instance and one SKIP_ZERO instance against a
// regset array model, with expected word lists built from the range rules.
module tb_regset_dump;
  import regset_dump_pkg::*;

  typedef struct {
    int          inst;
    int          addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, rst1;
  logic [31:0] regs [32];
  logic        start_d [2];
  logic [4:0]  first_d [2];
  logic [4:0]  last_d  [2];
  logic        rdy     [2];
  int          mode    [2];

  logic        v   [2];
  logic [4:0]  a   [2];
  logic [31:0] d   [2];
  logic        l   [2];
  logic        dn  [2];
  logic        bsy [2];
  logic [4:0]  aq  [2];

  regset_dump_if bus0 ();
  regset_dump_if bus1 ();

  regset_dump #(.SKIP_ZERO(1'b0)) dut0 (.CLK(clk), .RES(rst0), .bus(bus0));
  regset_dump #(.SKIP_ZERO(1'b1)) dut1 (.CLK(clk), .RES(rst1), .bus(bus1));

  assign bus0.start = start_d[0];  assign bus1.start = start_d[1];
  assign bus0.first_addr = first_d[0];  assign bus1.first_addr = first_d[1];
  assign bus0.last_addr = last_d[0];  assign bus1.last_addr = last_d[1];
  assign bus0.out_ready = rdy[0];  assign bus1.out_ready = rdy[1];
  assign bus0.Q = regs[bus0.A_Q];  assign bus1.Q = regs[bus1.A_Q];

  assign v[0] = bus0.out_valid;  assign v[1] = bus1.out_valid;
  assign a[0] = bus0.out_addr;   assign a[1] = bus1.out_addr;
  assign d[0] = bus0.out_data;   assign d[1] = bus1.out_data;
  assign l[0] = bus0.out_last;   assign l[1] = bus1.out_last;
  assign dn[0] = bus0.done;      assign dn[1] = bus1.done;
  assign bsy[0] = bus0.busy;     assign bsy[1] = bus1.busy;
  assign aq[0] = bus0.A_Q;       assign aq[1] = bus1.A_Q;

  int n_chk = 0;
  int n_fail = 0;

  word_t obs[$];
  int    exp_a[$];
  int    done_cnt [2];
  int    done_cyc [2];
  int    first_v_cyc [2];
  int    last_hs [2];
  logic        prev_stall [2];
  logic [4:0]  p_addr [2];
  logic [31:0] p_data [2];
  logic        p_last [2];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected address order: step through the range modulo 32, dropping 0 when skipped.
  function automatic void build_exp(input int f, input int lst, input bit skip);
    int x;
    exp_a.delete();
    x = f;
    for (int k = 0; k < 33; k++) begin
      if (!(skip && x == 0)) exp_a.push_back(x);
      if (x == lst) break;
      x = (x + 1) % 32;
    end
  endfunction

  // Consumer + monitor: choose ready for the coming edge, then record what that edge will do.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        case (mode[i])
          0:       rdy[i] = 1'b1;
          1:       rdy[i] = 1'($urandom_range(0, 1));
          default: rdy[i] = !(v[i] && a[i] == 5'd9);
        endcase
        if (v[i] && prev_stall[i]) begin
          chk_eq("hold_addr", 32'(a[i]), 32'(p_addr[i]));
          chk_eq("hold_data", d[i], p_data[i]);
          chk_eq("hold_last", 32'(l[i]), 32'(p_last[i]));
        end
        if (v[i] && first_v_cyc[i] < 0) first_v_cyc[i] = cyc;
        if (v[i] && rdy[i]) begin
          obs.push_back('{inst: i, addr: int'(a[i]), data: d[i], last: l[i]});
          last_hs[i] = cyc;
        end
        if (dn[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        prev_stall[i] = v[i] && !rdy[i];
        p_addr[i] = a[i];
        p_data[i] = d[i];
        p_last[i] = l[i];
      end
    end
  end

  task automatic clear_mon(input int inst);
    obs.delete();
    done_cnt[inst] = 0;
    done_cyc[inst] = -1;
    first_v_cyc[inst] = -1;
    last_hs[inst] = -1;
  endtask

  task automatic run_dump(input int inst, input int f, input int lst, input int md,
                          input bit inject, input string tag);
    int    s_cyc;
    word_t got[$];
    build_exp(f, lst, inst == 1);
    @(negedge clk);
    mode[inst] = md;
    clear_mon(inst);
    start_d[inst] = 1'b1;
    first_d[inst] = 5'(f);
    last_d[inst]  = 5'(lst);
    s_cyc = cyc;
    for (int k = 0; k < 400 && done_cnt[inst] == 0; k++) begin
      @(negedge clk);
      if (inject && k == 3) begin
        start_d[inst] = 1'b1;
        first_d[inst] = 5'd0;
        last_d[inst]  = 5'd0;
      end else begin
        start_d[inst] = 1'b0;
      end
    end
    start_d[inst] = 1'b0;
    repeat (12) @(negedge clk);
    mode[inst] = 0;
    chk_eq({tag, "_done_count"}, 32'(done_cnt[inst]), 32'd1);
    foreach (obs[j]) if (obs[j].inst == inst) got.push_back(obs[j]);
    chk_eq({tag, "_words"}, 32'(got.size()), 32'(exp_a.size()));
    for (int j = 0; j < exp_a.size() && j < got.size(); j++) begin
      chk_eq($sformatf("%s_addr%0d", tag, j), 32'(got[j].addr), 32'(exp_a[j]));
      chk_eq($sformatf("%s_data%0d", tag, j), got[j].data, regs[exp_a[j]]);
      chk_eq($sformatf("%s_last%0d", tag, j), 32'(got[j].last), 32'(j == exp_a.size() - 1));
    end
    if (exp_a.size() > 0) begin
      chk_eq({tag, "_first_valid_lat"}, 32'(first_v_cyc[inst] - s_cyc), 32'd2);
      chk_eq({tag, "_done_after_hs"}, 32'(done_cyc[inst] - last_hs[inst]), 32'd1);
    end else begin
      chk_eq({tag, "_no_valid"}, 32'(first_v_cyc[inst]), 32'hFFFF_FFFF);
      // done lands in the cycle after the start cycle (start cycle + FINISH cycle)
      chk_eq({tag, "_done_lat"}, 32'(done_cyc[inst] - s_cyc), 32'd1);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk_eq({tag, "_valid"}, 32'(v[i]), 32'd0);
    chk_eq({tag, "_busy"},  32'(bsy[i]), 32'd0);
    chk_eq({tag, "_done"},  32'(dn[i]), 32'd0);
    chk_eq({tag, "_aq"},    32'(aq[i]), 32'd0);
    chk_eq({tag, "_addr"},  32'(a[i]), 32'd0);
    chk_eq({tag, "_data"},  d[i], 32'd0);
    chk_eq({tag, "_last"},  32'(l[i]), 32'd0);
  endtask

  initial begin
    int f, lst, inst;
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_d[i] = 1'b0;
      first_d[i] = '0;
      last_d[i]  = '0;
      rdy[i]     = 1'b1;
      mode[i]    = 0;
      prev_stall[i] = 1'b0;
      done_cnt[i] = 0;
      first_v_cyc[i] = -1;
    end
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk_idle(0, "post_rst0");

    run_dump(0, 0, 31, 0, 1'b0, "full");
    run_dump(0, 5, 7, 1, 1'b0, "backpressure");
    run_dump(0, 30, 1, 0, 1'b0, "wrap");
    run_dump(0, 12, 12, 0, 1'b0, "single");
    run_dump(1, 31, 2, 0, 1'b0, "skip_wrap");
    run_dump(1, 0, 0, 0, 1'b0, "skip_empty");
    run_dump(1, 0, 3, 1, 1'b0, "skip_from0");

    // Reset while word 9 of 4..20 is stalled on the stream.
    @(negedge clk);
    clear_mon(0);
    mode[0] = 2;
    start_d[0] = 1'b1;
    first_d[0] = 5'd4;
    last_d[0]  = 5'd20;
    @(negedge clk);
    start_d[0] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (v[0] && a[0] == 5'd9 && !rdy[0]) break;
    end
    chk_eq("mid_reached_addr", 32'(a[0]), 32'd9);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("mid_rst_valid", 32'(v[0]), 32'd0);
    chk_eq("mid_rst_busy",  32'(bsy[0]), 32'd0);
    chk_eq("mid_rst_aq",    32'(aq[0]), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    mode[0] = 0;
    repeat (6) @(negedge clk);
    chk_eq("mid_rst_no_done", 32'(done_cnt[0]), 32'd0);
    run_dump(0, 3, 3, 0, 1'b0, "after_rst");

    run_dump(0, 10, 15, 0, 1'b1, "start_busy");

    for (int t = 0; t < 6; t++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      inst = int'($urandom_range(0, 1));
      f    = int'($urandom_range(0, 31));
      lst  = int'($urandom_range(0, 31));
      if (inst == 1 && lst == 0) lst = 1;
      run_dump(inst, f, lst, int'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
